// File: rtl/control_unit_mc.sv
// Multi-cycle control unit for the accumulator CPU.
// Fetch/execute sequencing with memory handshakes, HALT and retire count.
module control_unit_mc #(
    parameter int DATA_WIDTH        = 11,
    parameter int INSTRUCTION_WIDTH = 15,
    parameter int ALU_OP_WIDTH      = 3,
    parameter int COUNT_WIDTH       = 16,
    localparam int OPW = INSTRUCTION_WIDTH - DATA_WIDTH + 1
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic [OPW-1:0]          op_code,
    input  logic                    status_Z_in,
    input  logic                    status_N_in,
    input  logic                    imem_ready_in,
    input  logic                    dmem_ready_in,
    output logic                    imem_req_out,
    output logic                    dmem_req_out,
    output logic                    branch_out,
    output logic                    sel_B_out,
    output logic                    data_memory_wr_out,
    output logic                    acc_wr_out,
    output logic                    pc_wr_out,
    output logic                    status_wr_out,
    output logic                    ir_wr_out,
    output logic                    acc_reset_out,
    output logic                    pc_reset_out,
    output logic                    status_reset_out,
    output logic                    ir_reset_out,
    output logic [1:0]              sel_A_out,
    output logic [ALU_OP_WIDTH-1:0] alu_op_out,
    output logic                    halted_out,
    output logic                    illegal_op_out,
    output logic [COUNT_WIDTH-1:0]  retired_count_out
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [OPW-1:0] OP_HLT  = OPW'(5'h00);
    localparam logic [OPW-1:0] OP_STO  = OPW'(5'h01);
    localparam logic [OPW-1:0] OP_LD   = OPW'(5'h02);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'h03);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'h04);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'h05);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'h06);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(5'h07);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(5'h08);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(5'h09);
    localparam logic [OPW-1:0] OP_BGT  = OPW'(5'h0A);
    localparam logic [OPW-1:0] OP_BGE  = OPW'(5'h0B);
    localparam logic [OPW-1:0] OP_BLT  = OPW'(5'h0C);
    localparam logic [OPW-1:0] OP_BLE  = OPW'(5'h0D);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(5'h0E);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'h0F);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5'h10);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'h11);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'h12);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5'h13);
    localparam logic [OPW-1:0] OP_XORI = OPW'(5'h14);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'h15);

    state_t state, next_state;
    logic   alu_wr;
    logic   illegal_now;
    logic   retire;
    logic   z, n;

    assign z = status_Z_in;
    assign n = status_N_in;

    // State register; reset overrides any pending handshake.
    always_ff @(posedge clock_in) begin
        if (!reset_in) state <= S_RESET;
        else           state <= next_state;
    end

    // Next-state and strobe decode from state, opcode, flags and readies.
    always_comb begin
        next_state         = state;
        imem_req_out       = 1'b0;
        dmem_req_out       = 1'b0;
        branch_out         = 1'b0;
        sel_B_out          = 1'b0;
        data_memory_wr_out = 1'b0;
        acc_wr_out         = 1'b0;
        pc_wr_out          = 1'b0;
        status_wr_out      = 1'b0;
        ir_wr_out          = 1'b0;
        acc_reset_out      = 1'b0;
        pc_reset_out       = 1'b0;
        status_reset_out   = 1'b0;
        ir_reset_out       = 1'b0;
        sel_A_out          = 2'b00;
        alu_op_out         = '0;
        halted_out         = 1'b0;
        alu_wr             = 1'b0;
        illegal_now        = 1'b0;
        case (state)
            S_RESET: begin
                acc_reset_out    = 1'b1;
                pc_reset_out     = 1'b1;
                status_reset_out = 1'b1;
                ir_reset_out     = 1'b1;
                next_state       = S_FETCH;
            end
            S_FETCH: begin
                imem_req_out = 1'b1;
                if (imem_ready_in) begin
                    ir_wr_out  = 1'b1;
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                next_state = S_FETCH;
                case (op_code)
                    OP_HLT: next_state = S_HALT;
                    OP_STO: begin
                        dmem_req_out       = 1'b1;
                        data_memory_wr_out = 1'b1;
                        if (dmem_ready_in) pc_wr_out  = 1'b1;
                        else               next_state = S_EXEC;
                    end
                    OP_LD: begin
                        dmem_req_out = 1'b1;
                        if (dmem_ready_in) begin
                            acc_wr_out = 1'b1;
                            pc_wr_out  = 1'b1;
                        end else begin
                            next_state = S_EXEC;
                        end
                    end
                    OP_LDI: begin
                        sel_A_out  = 2'b01;
                        acc_wr_out = 1'b1;
                        pc_wr_out  = 1'b1;
                    end
                    OP_ADD:  alu_wr = 1'b1;
                    OP_ADDI: begin alu_wr = 1'b1; sel_B_out = 1'b1; end
                    OP_SUB: begin
                        alu_wr     = 1'b1;
                        alu_op_out = ALU_OP_WIDTH'(3'b001);
                    end
                    OP_SUBI: begin
                        alu_wr     = 1'b1;
                        sel_B_out  = 1'b1;
                        alu_op_out = ALU_OP_WIDTH'(3'b001);
                    end
                    OP_AND: begin
                        alu_wr     = 1'b1;
                        alu_op_out = ALU_OP_WIDTH'(3'b010);
                    end
                    OP_ANDI: begin
                        alu_wr     = 1'b1;
                        sel_B_out  = 1'b1;
                        alu_op_out = ALU_OP_WIDTH'(3'b010);
                    end
                    OP_OR: begin
                        alu_wr     = 1'b1;
                        alu_op_out = ALU_OP_WIDTH'(3'b011);
                    end
                    OP_ORI: begin
                        alu_wr     = 1'b1;
                        sel_B_out  = 1'b1;
                        alu_op_out = ALU_OP_WIDTH'(3'b011);
                    end
                    OP_XOR: begin
                        alu_wr     = 1'b1;
                        alu_op_out = ALU_OP_WIDTH'(3'b100);
                    end
                    OP_XORI: begin
                        alu_wr     = 1'b1;
                        sel_B_out  = 1'b1;
                        alu_op_out = ALU_OP_WIDTH'(3'b100);
                    end
                    OP_NOT: begin
                        alu_wr     = 1'b1;
                        alu_op_out = ALU_OP_WIDTH'(3'b101);
                    end
                    OP_BEQ: begin branch_out = z;       pc_wr_out = 1'b1; end
                    OP_BNE: begin branch_out = !z;      pc_wr_out = 1'b1; end
                    OP_BGT: begin branch_out = !z && !n; pc_wr_out = 1'b1; end
                    OP_BGE: begin branch_out = !n;      pc_wr_out = 1'b1; end
                    OP_BLT: begin branch_out = n;       pc_wr_out = 1'b1; end
                    OP_BLE: begin branch_out = z || n;  pc_wr_out = 1'b1; end
                    OP_JMP: begin branch_out = 1'b1;    pc_wr_out = 1'b1; end
                    default: begin
                        pc_wr_out   = 1'b1;
                        illegal_now = 1'b1;
                    end
                endcase
                if (alu_wr) begin
                    sel_A_out     = 2'b10;
                    acc_wr_out    = 1'b1;
                    status_wr_out = 1'b1;
                    pc_wr_out     = 1'b1;
                end
            end
            S_HALT: halted_out = 1'b1;
            default: next_state = S_RESET;
        endcase
    end

    assign retire = (state == S_EXEC) && pc_wr_out;

    // Saturating retire counter and sticky illegal-opcode flag.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            retired_count_out <= '0;
            illegal_op_out    <= 1'b0;
        end else begin
            if (retire && (retired_count_out != '1))
                retired_count_out <= retired_count_out + COUNT_WIDTH'(1);
            if (illegal_now)
                illegal_op_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed scoreboard bench for control_unit_mc.
// A second instance with COUNT_WIDTH=2 covers counter saturation.
module tb_control_unit_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] op;
    logic       z, n, iready, dready;

    logic imem_req, dmem_req, branch, sel_b, dmem_wr, acc_wr, pc_wr;
    logic status_wr, ir_wr, acc_rst, pc_rst, st_rst, ir_rst;
    logic [1:0]  sel_a;
    logic [2:0]  alu_op;
    logic        halted, illegal;
    logic [15:0] count;

    logic d2_imem_req, d2_dmem_req, d2_branch, d2_sel_b, d2_dmem_wr;
    logic d2_acc_wr, d2_pc_wr, d2_status_wr, d2_ir_wr;
    logic d2_acc_rst, d2_pc_rst, d2_st_rst, d2_ir_rst;
    logic [1:0] d2_sel_a;
    logic [2:0] d2_alu_op;
    logic       d2_halted, d2_illegal;
    logic [1:0] d2_count;

    always #5 clk = ~clk;

    control_unit_mc dut (
        .clock_in(clk), .reset_in(rst_n), .op_code(op),
        .status_Z_in(z), .status_N_in(n),
        .imem_ready_in(iready), .dmem_ready_in(dready),
        .imem_req_out(imem_req), .dmem_req_out(dmem_req),
        .branch_out(branch), .sel_B_out(sel_b),
        .data_memory_wr_out(dmem_wr), .acc_wr_out(acc_wr),
        .pc_wr_out(pc_wr), .status_wr_out(status_wr), .ir_wr_out(ir_wr),
        .acc_reset_out(acc_rst), .pc_reset_out(pc_rst),
        .status_reset_out(st_rst), .ir_reset_out(ir_rst),
        .sel_A_out(sel_a), .alu_op_out(alu_op), .halted_out(halted),
        .illegal_op_out(illegal), .retired_count_out(count)
    );

    control_unit_mc #(.COUNT_WIDTH(2)) dut2 (
        .clock_in(clk), .reset_in(rst_n), .op_code(op),
        .status_Z_in(z), .status_N_in(n),
        .imem_ready_in(iready), .dmem_ready_in(dready),
        .imem_req_out(d2_imem_req), .dmem_req_out(d2_dmem_req),
        .branch_out(d2_branch), .sel_B_out(d2_sel_b),
        .data_memory_wr_out(d2_dmem_wr), .acc_wr_out(d2_acc_wr),
        .pc_wr_out(d2_pc_wr), .status_wr_out(d2_status_wr),
        .ir_wr_out(d2_ir_wr),
        .acc_reset_out(d2_acc_rst), .pc_reset_out(d2_pc_rst),
        .status_reset_out(d2_st_rst), .ir_reset_out(d2_ir_rst),
        .sel_A_out(d2_sel_a), .alu_op_out(d2_alu_op),
        .halted_out(d2_halted), .illegal_op_out(d2_illegal),
        .retired_count_out(d2_count)
    );

    typedef struct packed {
        logic        imem_req, dmem_req, branch, sel_b, dmem_wr;
        logic        acc_wr, pc_wr, status_wr, ir_wr;
        logic [3:0]  rst;
        logic [1:0]  sel_a;
        logic [2:0]  alu;
        logic        halted, illegal;
        logic [15:0] count;
    } obs_t;

    obs_t  sb_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    mcnt = 0;
    logic  mill = 1'b0;

    function automatic obs_t get_obs();
        obs_t o;
        o.imem_req = imem_req; o.dmem_req = dmem_req; o.branch = branch;
        o.sel_b = sel_b; o.dmem_wr = dmem_wr; o.acc_wr = acc_wr;
        o.pc_wr = pc_wr; o.status_wr = status_wr; o.ir_wr = ir_wr;
        o.rst = {acc_rst, pc_rst, st_rst, ir_rst};
        o.sel_a = sel_a; o.alu = alu_op; o.halted = halted;
        o.illegal = illegal; o.count = count;
        return o;
    endfunction

    function automatic obs_t base();
        obs_t o = '0;
        o.count = 16'(mcnt);
        o.illegal = mill;
        return o;
    endfunction

    function automatic obs_t fetch_e(logic rdy);
        obs_t o = base();
        o.imem_req = 1'b1;
        o.ir_wr = rdy;
        return o;
    endfunction

    function automatic logic br_model(logic [4:0] code, logic fz, logic fn);
        case (code)
            5'h08: return fz;
            5'h09: return !fz;
            5'h0A: return !fz && !fn;
            5'h0B: return !fn;
            5'h0C: return fn;
            5'h0D: return fz || fn;
            default: return 1'b1;
        endcase
    endfunction

    // Push expectation, compare at the falling edge, advance past the rising edge.
    task automatic step(string tag, obs_t e, logic set_ill = 1'b0);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        begin
            obs_t  want = sb_q.pop_front();
            string t = tag_q.pop_front();
            obs_t  got = get_obs();
            n_checks++;
            assert (got === want) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", t, got, want);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            mcnt = 0;
            mill = 1'b0;
        end else begin
            if (e.pc_wr && mcnt < 65535) mcnt++;
            if (set_ill) mill = 1'b1;
        end
        #1;
    endtask

    task automatic do_fetch(logic [4:0] code);
        op = code;
        iready = 1'b1;
        step("fetch", fetch_e(1'b1));
        iready = 1'b0;
    endtask

    logic [4:0] t_op[11]  = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h0F,
                              5'h10, 5'h11, 5'h12, 5'h13, 5'h14};
    logic [2:0] t_alu[11] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                              3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
    logic       t_sb[11]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                              1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        obs_t e;
        obs_t rst_e;
        rst_n = 1'b0; op = 5'h00; z = 1'b0; n = 1'b0;
        iready = 1'b0; dready = 1'b0;
        @(posedge clk); #1;
        mcnt = 0; mill = 1'b0;
        rst_n = 1'b1;
        rst_e = '0;
        rst_e.rst = 4'hF;
        step("reset_state", rst_e);

        op = 5'h05;
        for (int i = 0; i < 3; i++) step("fetch_wait", fetch_e(1'b0));
        iready = 1'b1;
        step("fetch_ready", fetch_e(1'b1));
        iready = 1'b0;
        e = base();
        e.sel_a = 2'b10; e.sel_b = 1'b1; e.acc_wr = 1'b1;
        e.status_wr = 1'b1; e.pc_wr = 1'b1;
        step("exec_addi", e);

        do_fetch(5'h01);
        for (int i = 0; i < 2; i++) begin
            e = base(); e.dmem_req = 1'b1; e.dmem_wr = 1'b1;
            step("sto_wait", e);
        end
        dready = 1'b1;
        e = base(); e.dmem_req = 1'b1; e.dmem_wr = 1'b1; e.pc_wr = 1'b1;
        step("sto_done", e);
        dready = 1'b0;

        do_fetch(5'h02);
        e = base(); e.dmem_req = 1'b1;
        step("ld_wait", e);
        dready = 1'b1;
        e = base(); e.dmem_req = 1'b1; e.acc_wr = 1'b1; e.pc_wr = 1'b1;
        step("ld_done", e);
        dready = 1'b0;

        do_fetch(5'h02);
        e = base(); e.dmem_req = 1'b1;
        step("ld_wait2", e);
        rst_n = 1'b0;
        e = base(); e.dmem_req = 1'b1;
        step("ld_wait_rst", e);
        rst_n = 1'b1;
        step("reset_mid_ld", rst_e);
        step("fetch_after_rst", fetch_e(1'b0));

        for (int c = 8; c <= 14; c++) begin
            for (int f = 0; f < 4; f++) begin
                do_fetch(5'(c));
                z = f[1]; n = f[0];
                e = base(); e.pc_wr = 1'b1;
                e.branch = br_model(5'(c), f[1], f[0]);
                step($sformatf("branch_%0h_zn%0d", c, f), e);
            end
        end
        z = 1'b0; n = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_fetch(t_op[i]);
            e = base(); e.pc_wr = 1'b1; e.acc_wr = 1'b1;
            if (t_op[i] == 5'h03) begin
                e.sel_a = 2'b01;
            end else begin
                e.sel_a = 2'b10; e.status_wr = 1'b1;
                e.alu = t_alu[i]; e.sel_b = t_sb[i];
            end
            step($sformatf("alu_op_%0h", t_op[i]), e);
        end
        do_fetch(5'h15);
        e = base(); e.pc_wr = 1'b1; e.acc_wr = 1'b1; e.status_wr = 1'b1;
        e.sel_a = 2'b10; e.alu = 3'b101;
        step("not_op", e);

        do_fetch(5'h1F);
        e = base(); e.pc_wr = 1'b1;
        step("illegal_1f", e, 1'b1);
        do_fetch(5'h04);
        e = base(); e.pc_wr = 1'b1; e.acc_wr = 1'b1; e.status_wr = 1'b1;
        e.sel_a = 2'b10;
        step("add_after_ill", e);

        rst_n = 1'b0;
        step("fetch_pre_rst", fetch_e(1'b0));
        rst_n = 1'b1;
        step("reset_clear", rst_e);
        for (int i = 0; i < 5; i++) begin
            do_fetch(5'h16);
            e = base(); e.pc_wr = 1'b1;
            step("illegal_16", e, 1'b1);
        end
        n_checks++;
        assert (d2_count === 2'd3) else begin
            n_fail++;
            $error("FAIL sat_count: observed %0d expected 3", d2_count);
        end

        do_fetch(5'h00);
        step("exec_hlt", base());
        iready = 1'b1; dready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e = base(); e.halted = 1'b1;
            step("halt", e);
        end
        iready = 1'b0; dready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
